// File: rtl/ray_bounce_arbiter_if.sv
// Bundle of ray traffic between the arbiter and its neighbours: primary and
// reflection write ports, the issue port towards raster, and status/retire signals.
interface ray_bounce_arbiter_if #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned MAX_BOUNCE   = 3,
    parameter int unsigned MAX_INFLIGHT = 8
);
    localparam int unsigned BW = $clog2(MAX_BOUNCE + 1);
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

    logic              add_input;
    logic [DATA_W-1:0] input_data;
    logic              fifo_full;
    logic              add_ref_input;
    logic [DATA_W-1:0] ref_input_data;
    logic [BW-1:0]     ref_bounce;
    logic              ref_fifo_full;
    logic              output_fifo_full;
    logic              valid;
    logic [DATA_W-1:0] out;
    logic [BW-1:0]     out_bounce;
    logic              retire;
    logic [IW-1:0]     inflight;
    logic              overflow;
    logic              drop;

    // Producer / consumer side (ray generator, shader, raster, frame buffer)
    modport master (
        output add_input, input_data, add_ref_input, ref_input_data, ref_bounce,
        output output_fifo_full, retire,
        input  fifo_full, ref_fifo_full, valid, out, out_bounce, inflight, overflow, drop
    );

    // Arbiter side
    modport slave (
        input  add_input, input_data, add_ref_input, ref_input_data, ref_bounce,
        input  output_fifo_full, retire,
        output fifo_full, ref_fifo_full, valid, out, out_bounce, inflight, overflow, drop
    );
endinterface

// File: rtl/ray_bounce_arbiter.sv
// Ray bounce arbiter: merges fresh primary rays with reflection rays fed back
// from the shader. Feedback normally wins so bounced rays drain first, primary
// admission is capped by an in-flight budget, and a streak counter forces a
// primary grant after STARVE_LIMIT back-to-back feedback issues.
module ray_bounce_arbiter #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned MAX_BOUNCE   = 3,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    ray_bounce_arbiter_if.slave        bus
);
    localparam int unsigned BW = $clog2(MAX_BOUNCE + 1);
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [PW:0]   DEPTH_V   = (PW + 1)'(DEPTH);
    localparam logic [IW-1:0] MAX_INF_V = IW'(MAX_INFLIGHT);
    localparam logic [BW-1:0] MAX_BNC_V = BW'(MAX_BOUNCE);
    localparam logic [SW-1:0] STARVE_V  = SW'(STARVE_LIMIT);

    logic [DATA_W-1:0] pri_mem_q [DEPTH];
    logic [DATA_W-1:0] fb_mem_q  [DEPTH];
    logic [BW-1:0]     fb_bnc_q  [DEPTH];

    logic [PW:0]       pri_wr_q, pri_wr_d, pri_rd_q, pri_rd_d;
    logic [PW:0]       fb_wr_q, fb_wr_d, fb_rd_q, fb_rd_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [BW-1:0]     out_bounce_q, out_bounce_d;
    logic              overflow_q, overflow_d;
    logic              drop_q, drop_d;

    logic [PW:0] pri_cnt, fb_cnt;
    logic        pri_full, fb_full, pri_empty, fb_empty, pri_elig, ref_legal;
    logic        pri_wr, fb_wr, discard, pri_pick, fb_pick, underflow;
    int          net;

    // Next-state: FIFO pointers, grant decision, in-flight accounting, outputs
    always_comb begin
        pri_cnt   = pri_wr_q - pri_rd_q;
        fb_cnt    = fb_wr_q - fb_rd_q;
        pri_full  = (pri_cnt == DEPTH_V);
        fb_full   = (fb_cnt == DEPTH_V);
        pri_empty = (pri_cnt == '0);
        fb_empty  = (fb_cnt == '0);
        pri_elig  = !pri_empty && (inflight_q < MAX_INF_V);
        ref_legal = (bus.ref_bounce < MAX_BNC_V);

        pri_wr  = bus.add_input && !pri_full;
        fb_wr   = bus.add_ref_input && ref_legal && !fb_full;
        discard = bus.add_ref_input && !ref_legal;

        // Feedback first, except when primary has been starved long enough
        fb_pick  = !bus.output_fifo_full && !fb_empty && !((streak_q == STARVE_V) && pri_elig);
        pri_pick = !bus.output_fifo_full && !fb_pick && pri_elig;

        pri_wr_d = pri_wr_q + (PW + 1)'(pri_wr);
        pri_rd_d = pri_rd_q + (PW + 1)'(pri_pick);
        fb_wr_d  = fb_wr_q + (PW + 1)'(fb_wr);
        fb_rd_d  = fb_rd_q + (PW + 1)'(fb_pick);

        // Net in-flight change folded into one update; clamp at zero
        net       = int'(inflight_q) + int'(pri_pick) - int'(bus.retire) - int'(discard);
        underflow = (net < 0);
        inflight_d = underflow ? '0 : IW'(net);

        streak_d = streak_q;
        if (pri_pick) begin
            streak_d = '0;
        end else if (fb_pick && pri_elig && (streak_q != STARVE_V)) begin
            streak_d = streak_q + SW'(1);
        end

        valid_d      = pri_pick || fb_pick;
        out_d        = out_q;
        out_bounce_d = out_bounce_q;
        if (fb_pick) begin
            out_d        = fb_mem_q[fb_rd_q[PW-1:0]];
            out_bounce_d = fb_bnc_q[fb_rd_q[PW-1:0]];
        end else if (pri_pick) begin
            out_d        = pri_mem_q[pri_rd_q[PW-1:0]];
            out_bounce_d = '0;
        end

        drop_d     = discard;
        overflow_d = overflow_q
                   || (bus.add_input && pri_full)
                   || (bus.add_ref_input && ref_legal && fb_full)
                   || underflow;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pri_wr_q     <= '0;
            pri_rd_q     <= '0;
            fb_wr_q      <= '0;
            fb_rd_q      <= '0;
            inflight_q   <= '0;
            streak_q     <= '0;
            valid_q      <= 1'b0;
            out_q        <= '0;
            out_bounce_q <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            pri_wr_q     <= pri_wr_d;
            pri_rd_q     <= pri_rd_d;
            fb_wr_q      <= fb_wr_d;
            fb_rd_q      <= fb_rd_d;
            inflight_q   <= inflight_d;
            streak_q     <= streak_d;
            valid_q      <= valid_d;
            out_q        <= out_d;
            out_bounce_q <= out_bounce_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define occupancy
    always_ff @(posedge clk) begin
        if (!reset && pri_wr) begin
            pri_mem_q[pri_wr_q[PW-1:0]] <= bus.input_data;
        end
        if (!reset && fb_wr) begin
            fb_mem_q[fb_wr_q[PW-1:0]] <= bus.ref_input_data;
            fb_bnc_q[fb_wr_q[PW-1:0]] <= bus.ref_bounce + BW'(1);
        end
    end

    assign bus.fifo_full     = pri_full;
    assign bus.ref_fifo_full = fb_full;
    assign bus.valid         = valid_q;
    assign bus.out           = out_q;
    assign bus.out_bounce    = out_bounce_q;
    assign bus.inflight      = inflight_q;
    assign bus.overflow      = overflow_q;
    assign bus.drop          = drop_q;
endmodule
